clk_divider_bank: RTL and testbench

Parametrised multi-channel clock divider that derives NCH independent slow rates from the system clock OCLK. Each channel has an exact integer divisor, not only a power of two, that can be reprogrammed at run time. Each channel provides a one-cycle `tick` enable and a near-50 % `clk_out` square wave. It feeds the scan, display and input-sampling logic, and all channels can be phase-aligned with a single strobe.

---
 rtl/clk_divider_bank_if.sv | 26 ++
 rtl/clk_divider_bank.sv | 105 ++++++++++
 tb/tb_clk_divider_bank.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_divider_bank_if.sv
// Control and status bundle for clk_divider_bank: enable, phase-align strobe,
// divisor load port and the per-channel tick / clk_out / pend outputs.
interface clk_divider_bank_if #(
   parameter int NCH  = 3,
   parameter int DIVW = 18,
   parameter int CHW  = 2
);
   logic            en;
   logic            sync;
   logic            ld;
   logic [CHW-1:0]  ld_ch;
   logic [DIVW-1:0] ld_div;
   logic [NCH-1:0]  tick;
   logic [NCH-1:0]  clk_out;
   logic [NCH-1:0]  pend;

   modport master (
      output en, sync, ld, ld_ch, ld_div,
      input  tick, clk_out, pend
   );

   modport slave (
      input  en, sync, ld, ld_ch, ld_div,
      output tick, clk_out, pend
   );
endinterface

// File: rtl/clk_divider_bank.sv
// Multi-channel integer clock divider: per-channel tick pulse and near-50% clk_out,
// run-time divisor reload applied at the period boundary, and a global phase-align strobe.
module clk_divider_bank #(
   parameter int                  NCH      = 3,
   parameter int                  DIVW     = 18,
   parameter int                  CHW      = 2,
   parameter logic [NCH*DIVW-1:0] DIV_INIT = {18'd65536, 18'd131072, 18'd16384}
) (
   input logic               OCLK,
   input logic               rst,
   clk_divider_bank_if.slave bus
);

   logic [NCH-1:0] tick_v;
   logic [NCH-1:0] clk_v;
   logic [NCH-1:0] pend_v;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [DIVW-1:0] cnt;
      logic [DIVW-1:0] div;
      logic [DIVW-1:0] nxt;
      logic            pend_r;
      logic            tick_r;
      logic            clk_r;
      logic            hit;
      logic            active;
      logic            wrap;
      logic            load_now;
      logic [DIVW-1:0] cnt_n;
      logic [DIVW-1:0] div_n;

      assign hit      = bus.ld && (bus.ld_ch == CHW'(c));
      assign active   = bus.en && (div != '0);
      // div-1 is only meaningful while active, which already excludes div==0
      assign wrap     = active && (cnt == div - DIVW'(1));
      assign load_now = hit && (div == '0);

      always_comb begin
         cnt_n = cnt;
         div_n = div;
         if (wrap) begin
            cnt_n = '0;
            if (hit) begin
               div_n = bus.ld_div;
            end else if (pend_r) begin
               div_n = nxt;
            end
         end else if (load_now) begin
            cnt_n = '0;
            div_n = bus.ld_div;
         end else if (active) begin
            cnt_n = cnt + DIVW'(1);
         end
      end

      always_ff @(posedge OCLK) begin
         if (!rst) begin
            cnt    <= '0;
            div    <= DIV_INIT[c*DIVW +: DIVW];
            nxt    <= '0;
            pend_r <= 1'b0;
            tick_r <= 1'b0;
            clk_r  <= 1'b0;
         end else if (bus.sync) begin
            cnt    <= '0;
            tick_r <= 1'b0;
            clk_r  <= 1'b0;
            pend_r <= 1'b0;
            if (hit) begin
               div <= bus.ld_div;
               nxt <= bus.ld_div;
            end else if (pend_r) begin
               div <= nxt;
            end
         end else begin
            cnt    <= cnt_n;
            div    <= div_n;
            tick_r <= wrap;
            if (hit) begin
               nxt <= bus.ld_div;
            end
            if (wrap || load_now) begin
               pend_r <= 1'b0;
            end else if (hit) begin
               pend_r <= 1'b1;
            end
            // compare against next-state values so the falling edge lands on the tick
            if (div_n == '0) begin
               clk_r <= 1'b0;
            end else if (active) begin
               clk_r <= (cnt_n >= (div_n >> 1));
            end
         end
      end

      assign tick_v[c] = tick_r;
      assign clk_v[c]  = clk_r;
      assign pend_v[c] = pend_r;
   end

   assign bus.tick    = tick_v;
   assign bus.clk_out = clk_v;
   assign bus.pend    = pend_v;

endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed scenarios plus randomized traffic for clk_divider_bank, every edge
// compared against a per-channel period model.
module tb_clk_divider_bank;
   localparam int NCH  = 3;
   localparam int DIVW = 18;
   localparam int CHW  = 2;
   localparam int INIT [NCH] = '{16384, 131072, 65536};

   logic OCLK = 1'b0;
   logic rst;

   clk_divider_bank_if #(.NCH(NCH), .DIVW(DIVW), .CHW(CHW)) bus ();

   clk_divider_bank #(.NCH(NCH), .DIVW(DIVW), .CHW(CHW)) dut (
      .OCLK (OCLK),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 OCLK = ~OCLK;

   int vectors = 0;
   int miscompares = 0;
   int cyc_n = 0;

   // reference: position in period, active / pending divisor, registered outputs
   int m_pos  [NCH];
   int m_div  [NCH];
   int m_nxt  [NCH];
   bit m_pend [NCH];
   bit m_tick [NCH];
   bit m_clk  [NCH];

   int tick_cnt   [NCH];
   int first_tick [NCH];
   int last_tick  [NCH];
   int hi_cnt     [NCH];

   task automatic model_edge(input bit r, input bit e, input bit s, input bit l,
                             input int lc, input int lv);
      for (int c = 0; c < NCH; c++) begin
         bit hit, running, wrapped;
         hit = l && (lc == c);
         if (!r) begin
            m_pos[c] = 0; m_div[c] = INIT[c]; m_nxt[c] = 0;
            m_pend[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
         end else if (s) begin
            m_pos[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
            if (hit) begin
               m_div[c] = lv; m_nxt[c] = lv;
            end else if (m_pend[c]) begin
               m_div[c] = m_nxt[c];
            end
            m_pend[c] = 0;
         end else begin
            running = e && (m_div[c] > 0);
            wrapped = running && (m_pos[c] + 1 == m_div[c]);
            m_tick[c] = wrapped;
            if (hit) m_nxt[c] = lv;
            if (wrapped) begin
               m_pos[c] = 0;
               if (hit) m_div[c] = lv;
               else if (m_pend[c]) m_div[c] = m_nxt[c];
               m_pend[c] = 0;
            end else if (hit && m_div[c] == 0) begin
               m_div[c] = lv; m_pos[c] = 0; m_pend[c] = 0;
            end else begin
               if (hit) m_pend[c] = 1;
               if (running) m_pos[c] = m_pos[c] + 1;
            end
            if (m_div[c] == 0) m_clk[c] = 0;
            else if (running) m_clk[c] = (m_pos[c] >= m_div[c] / 2);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc_n, got, exp);
      end
   endtask

   task automatic check_model();
      logic [NCH-1:0] et, ec, ep;
      for (int c = 0; c < NCH; c++) begin
         et[c] = m_tick[c]; ec[c] = m_clk[c]; ep[c] = m_pend[c];
      end
      vectors++;
      assert (bus.tick === et) else begin
         miscompares++;
         $error("FAIL model_tick cyc=%0d got=%b exp=%b", cyc_n, bus.tick, et);
      end
      vectors++;
      assert (bus.clk_out === ec) else begin
         miscompares++;
         $error("FAIL model_clk cyc=%0d got=%b exp=%b", cyc_n, bus.clk_out, ec);
      end
      vectors++;
      assert (bus.pend === ep) else begin
         miscompares++;
         $error("FAIL model_pend cyc=%0d got=%b exp=%b", cyc_n, bus.pend, ep);
      end
   endtask

   task automatic clear_stats();
      for (int c = 0; c < NCH; c++) begin
         tick_cnt[c] = 0; first_tick[c] = 0; last_tick[c] = 0; hi_cnt[c] = 0;
      end
   endtask

   task automatic step();
      @(posedge OCLK);
      model_edge(rst, bus.en, bus.sync, bus.ld, int'(bus.ld_ch), int'(bus.ld_div));
      #1;
      cyc_n++;
      check_model();
      for (int c = 0; c < NCH; c++) begin
         if (bus.tick[c] === 1'b1) begin
            tick_cnt[c]++;
            if (first_tick[c] == 0) first_tick[c] = cyc_n;
            last_tick[c] = cyc_n;
         end
         if (bus.clk_out[c] === 1'b1) hi_cnt[c]++;
      end
   endtask

   task automatic load(input int ch, input int val);
      bus.ld = 1'b1; bus.ld_ch = CHW'(ch); bus.ld_div = DIVW'(val);
      step();
      bus.ld = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc_n);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t_ref;
      logic [NCH-1:0] held;
      rst = 1'b0;
      bus.en = 1'b0; bus.sync = 1'b0; bus.ld = 1'b0; bus.ld_ch = '0; bus.ld_div = '0;
      step();
      step();
      chk("rst_tick", bus.tick, 0);
      chk("rst_clk", bus.clk_out, 0);
      chk("rst_pend", bus.pend, 0);

      // defaults: ch0 16384, ch1 131072, ch2 65536
      rst = 1'b1; bus.en = 1'b1; cyc_n = 0; clear_stats();
      repeat (32768) step();
      chk("t1_ch0_first", first_tick[0], 16384);
      chk("t1_ch0_count", tick_cnt[0], 2);
      chk("t1_ch0_duty", hi_cnt[0], 16384);
      chk("t1_ch1_count", tick_cnt[1], 0);
      chk("t1_ch2_count", tick_cnt[2], 0);
      chk("t1_ch2_rise", hi_cnt[2], 1);

      // mid-period reload of ch0 waits for the boundary
      repeat (1000) step();
      load(0, 5);
      chk("t2_pend_set", bus.pend[0], 1);
      for (int i = 0; i < 20000 && bus.tick[0] !== 1'b1; i++) step();
      chk("t2_wrap_seen", bus.tick[0], 1);
      chk("t2_pend_clr", bus.pend[0], 0);
      t_ref = cyc_n; clear_stats();
      repeat (10) step();
      chk("t2_ticks", tick_cnt[0], 2);
      chk("t2_first", first_tick[0], t_ref + 5);
      chk("t2_duty", hi_cnt[0], 6);

      // shorten ch2 via sync, then reload it exactly on its wrap edge
      load(2, 8);
      bus.sync = 1'b1; step(); bus.sync = 1'b0;
      for (int i = 0; i < 20 && m_pos[2] != m_div[2] - 1; i++) step();
      load(2, 3);
      chk("t3_wrap_tick", bus.tick[2], 1);
      chk("t3_no_pend", bus.pend[2], 0);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("t3_pend", bus.pend[2], 0);
         chk("t3_tick", bus.tick[2], (k == 3) ? 1 : 0);
      end

      // disable ch1, then enable it from a dead start
      load(1, 0);
      chk("t4_pend0", bus.pend[1], 1);
      bus.sync = 1'b1; step(); bus.sync = 1'b0;
      clear_stats();
      repeat (20) step();
      chk("t4_off_ticks", tick_cnt[1], 0);
      chk("t4_off_hi", hi_cnt[1], 0);
      load(1, 4);
      t_ref = cyc_n; clear_stats();
      for (int i = 0; i < 10 && tick_cnt[1] == 0; i++) step();
      chk("t4_first", first_tick[1], t_ref + 4);

      // en gap stretches a ch0=7 period by exactly the gap length
      load(0, 7);
      for (int i = 0; i < 40 && !(m_div[0] == 7 && m_pos[0] == 3); i++) step();
      t_ref = last_tick[0];
      held = bus.clk_out;
      bus.en = 1'b0;
      repeat (10) begin
         step();
         chk("t5_tick_off", bus.tick, 0);
         chk("t5_clk_hold", bus.clk_out, held);
      end
      bus.en = 1'b1;
      for (int i = 0; i < 20 && bus.tick[0] !== 1'b1; i++) step();
      chk("t5_period", cyc_n - t_ref, 17);

      // pending ch0/ch2 plus direct ch1 load, all aligned by sync
      bus.en = 1'b0;
      load(0, 4);
      load(2, 6);
      chk("t6_pend", bus.pend, 3'b101);
      bus.sync = 1'b1; bus.en = 1'b1;
      load(1, 2);
      bus.sync = 1'b0;
      chk("t6_sync_tick", bus.tick, 0);
      chk("t6_sync_clk", bus.clk_out, 0);
      chk("t6_sync_pend", bus.pend, 0);
      for (int k = 1; k <= 12; k++) begin
         step();
         chk("t6_align", bus.tick, {(k % 6) == 0, (k % 2) == 0, (k % 4) == 0});
      end
      repeat (3) step();
      rst = 1'b0; step();
      chk("t6_rst_tick", bus.tick, 0);
      chk("t6_rst_clk", bus.clk_out, 0);
      chk("t6_rst_pend", bus.pend, 0);
      rst = 1'b1; cyc_n = 0; clear_stats();
      repeat (8191) step();
      chk("t6_init_low", bus.clk_out[0], 0);
      step();
      chk("t6_init_rise", bus.clk_out[0], 1);
      chk("t6_no_ticks", tick_cnt[0] + tick_cnt[1] + tick_cnt[2], 0);

      // randomized traffic, including out-of-range channels and divisors 0/1
      for (int i = 0; i < 3000; i++) begin
         bus.en     = ($urandom_range(0, 7) != 0);
         bus.sync   = ($urandom_range(0, 59) == 0);
         bus.ld     = ($urandom_range(0, 4) == 0);
         bus.ld_ch  = CHW'($urandom_range(0, 3));
         bus.ld_div = DIVW'($urandom_range(0, 9));
         step();
      end
      bus.sync = 1'b0; bus.ld = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
